// File: rtl/memory_access_if.sv
// memory_access_if: single-outstanding req/ack data-memory bus between memory stage and data memory
`ifndef XLEN
`define XLEN 32
`endif
interface memory_access_if;
  logic             req;
  logic             we;
  logic [`XLEN-1:0] addr;
  logic [`XLEN-1:0] wdata;
  logic [3:0]       be;
  logic             ack;
  logic [`XLEN-1:0] rdata;
  modport master(output req, we, addr, wdata, be, input ack, rdata);
  modport slave(input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/memory_access.sv
// memory_access: memory stage with req/ack data bus, byte-lane stores, extended loads and timeout abort.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse or_misaligned.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XADDR
`define XADDR 5
`endif
`ifndef OPLEN
`define OPLEN 4
`endif
module memory_access #(
  parameter int WAIT_MAX = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [`OPLEN:0]   i_opcode,
  input  logic [`XADDR-1:0] i_rd_addr,
  input  logic [`XLEN-1:0]  i_alu_result,
  input  logic [`XLEN-1:0]  i_rs2_data,
  input  logic [2:0]        i_funct3,
  input  logic [`XLEN-1:0]  i_pc,
  output logic              o_stall,
  output logic [`XLEN-1:0]  ow_rd_mem,
  output logic [`XADDR-1:0] ow_rd_addr_mem,
  output logic              ow_rd_mem_wr_en,
  memory_access_if.master   dmem,
  output logic [`OPLEN:0]   or_opcode,
  output logic [`XADDR-1:0] or_rd_addr,
  output logic [`XLEN-1:0]  or_rd_data,
  output logic              or_rd_wr_en,
  output logic [`XLEN-1:0]  or_pc,
  output logic              or_bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              or_misaligned
`endif
);
  localparam logic [`OPLEN:0] R_OP = 1, I_OP = 2, L_OP = 3, S_OP = 4, JAL_OP = 6, JALR_OP = 7,
                              LUI_OP = 8, AUIPC_OP = 9;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state;
  logic [7:0]       cnt;
  logic [1:0]       a;
  logic             is_ld, is_st, is_jmp, mem_op, wr_rd, mis, start, done, abort, rec_clr, rec_ld;
  logic [3:0]       be_n;
  logic [`XLEN-1:0] wdata_n, ld_data, rd_data_n;
  logic [7:0]       lb;
  logic [15:0]      lh;
  assign a      = i_alu_result[1:0];
  assign is_ld  = i_opcode == L_OP;
  assign is_st  = i_opcode == S_OP;
  assign is_jmp = i_opcode == JAL_OP || i_opcode == JALR_OP;
  assign mem_op = is_ld || is_st;
  assign wr_rd  = is_ld || is_jmp || i_opcode inside {R_OP, I_OP, LUI_OP, AUIPC_OP};
`ifdef MEM_MISALIGN_TRAP_EN
  // funct3[1:0] gives the access size, so unsigned loads are judged like their signed forms
  assign mis = mem_op && (i_funct3[1:0] == 2'b00 ? 1'b0 : i_funct3[1:0] == 2'b01 ? a[0] : a != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign start   = state == IDLE && mem_op && !mis;
  assign done    = state == BUSY && dmem.ack;
  assign abort   = state == BUSY && !dmem.ack && cnt == 8'(WAIT_MAX - 1);
  assign rec_clr = start || abort;
  assign rec_ld  = (state == IDLE && !start) || done;
  assign o_stall = start || (state == BUSY && !dmem.ack && !abort);
  assign ow_rd_mem       = i_alu_result;
  assign ow_rd_addr_mem  = i_rd_addr;
  assign ow_rd_mem_wr_en = wr_rd && !is_ld && !is_jmp && i_rd_addr != '0;
  assign lb = dmem.rdata[{a, 3'b000} +: 8];
  assign lh = dmem.rdata[{a[1], 4'b0000} +: 16];
  always_comb begin
    be_n      = i_funct3 == 3'b000 ? 4'b0001 << a : i_funct3 == 3'b001 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_n   = i_funct3 == 3'b000 ? {4{i_rs2_data[7:0]}} : i_funct3 == 3'b001 ? {2{i_rs2_data[15:0]}} : i_rs2_data;
    ld_data   = i_funct3 == 3'b000 ? {{24{lb[7]}}, lb} :
                i_funct3 == 3'b001 ? {{16{lh[15]}}, lh} :
                i_funct3 == 3'b100 ? {24'b0, lb} :
                i_funct3 == 3'b101 ? {16'b0, lh} : dmem.rdata;
    rd_data_n = is_jmp ? i_pc + 32'd4 : (done && is_ld) ? ld_data : i_alu_result;
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dmem.req    <= 1'b0;
      dmem.we     <= 1'b0;
      dmem.addr   <= '0;
      dmem.wdata  <= '0;
      dmem.be     <= '0;
      or_opcode   <= '0;
      or_rd_addr  <= '0;
      or_rd_data  <= '0;
      or_rd_wr_en <= 1'b0;
      or_pc       <= '0;
      or_bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      or_misaligned <= 1'b0;
`endif
    end else begin
      cnt        <= state == BUSY ? cnt + 8'd1 : 8'd0;
      or_bus_err <= abort;
`ifdef MEM_MISALIGN_TRAP_EN
      or_misaligned <= state == IDLE && mis;
`endif
      if (start) begin
        state      <= BUSY;
        dmem.req   <= 1'b1;
        dmem.we    <= is_st;
        dmem.addr  <= {i_alu_result[`XLEN-1:2], 2'b00};
        dmem.wdata <= wdata_n;
        dmem.be    <= be_n;
      end else if (done || abort) begin
        state    <= IDLE;
        dmem.req <= 1'b0;
      end
      if (rec_clr) begin
        or_opcode   <= '0;
        or_rd_addr  <= '0;
        or_rd_data  <= '0;
        or_rd_wr_en <= 1'b0;
        or_pc       <= '0;
      end else if (rec_ld) begin
        or_opcode   <= i_opcode;
        or_rd_addr  <= i_rd_addr;
        or_rd_data  <= rd_data_n;
        or_rd_wr_en <= wr_rd && !mis && i_rd_addr != '0;
        or_pc       <= i_pc;
      end
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized instruction stream checked every cycle against a transaction-level model.
module tb_memory_access;
  localparam int WM = 8;
  localparam logic [4:0] R_OP = 1, I_OP = 2, L_OP = 3, S_OP = 4, B_OP = 5, JAL_OP = 6, JALR_OP = 7,
                         LUI_OP = 8, AUIPC_OP = 9, SYS_OP = 10;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [4:0]  op, rd, or_opcode, or_rd_addr, ow_rd_addr_mem;
  logic [31:0] alu, rs2, pc, ow_rd_mem, or_rd_data, or_pc;
  logic [2:0]  f3;
  logic        o_stall, ow_rd_mem_wr_en, or_rd_wr_en, or_bus_err, or_misaligned;
  memory_access_if bus();
  memory_access #(.WAIT_MAX(WM)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(op), .i_rd_addr(rd), .i_alu_result(alu),
    .i_rs2_data(rs2), .i_funct3(f3), .i_pc(pc), .o_stall(o_stall), .ow_rd_mem(ow_rd_mem),
    .ow_rd_addr_mem(ow_rd_addr_mem), .ow_rd_mem_wr_en(ow_rd_mem_wr_en), .dmem(bus),
    .or_opcode(or_opcode), .or_rd_addr(or_rd_addr), .or_rd_data(or_rd_data),
    .or_rd_wr_en(or_rd_wr_en), .or_pc(or_pc), .or_bus_err(or_bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .or_misaligned(or_misaligned)
`endif
  );
`ifndef MEM_MISALIGN_TRAP_EN
  assign or_misaligned = 1'b0;
`endif
  int checks = 0, errors = 0, stall_cnt = 0;
  logic chk = 1'b0;
  logic e_stall, e_req, e_we, e_wen, e_err, e_mis;
  logic [3:0] e_be, lb_be;
  logic [4:0] e_op, e_rd;
  logic [31:0] e_addr, e_wdata, e_data, e_pc, lb_wd, lb_addr;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic writes_rd(input logic [4:0] o);
    return o inside {R_OP, I_OP, L_OP, LUI_OP, AUIPC_OP, JAL_OP, JALR_OP};
  endfunction
  function automatic logic fwd_wen(input logic [4:0] o, input logic [4:0] r);
    return o inside {R_OP, I_OP, LUI_OP, AUIPC_OP} && r != 0;
  endfunction
  function automatic logic misaligned(input logic [4:0] o, input logic [2:0] f, input int a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (o != L_OP && o != S_OP) return 1'b0;
    if (f[1:0] == 2'b00) return 1'b0;
    if (f[1:0] == 2'b01) return a % 2 == 1;
    return a != 0;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [3:0] ref_be(input logic [2:0] f, input int a);
    if (f == 3'b000) return 4'(1 << a);
    if (f == 3'b001) return a >= 2 ? 4'hC : 4'h3;
    return 4'hF;
  endfunction
  function automatic logic [31:0] ref_wd(input logic [2:0] f, input logic [31:0] s);
    if (f == 3'b000) return s[7:0] * 32'h01010101;
    if (f == 3'b001) return s[15:0] * 32'h00010001;
    return s;
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] f, input int a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * (a / 2))) & 32'hFFFF;
    if (f == 3'b000) return b >= 128 ? b - 256 : b;
    if (f == 3'b001) return h >= 32768 ? h - 65536 : h;
    if (f == 3'b100) return b;
    if (f == 3'b101) return h;
    return d;
  endfunction
  task automatic set_rec(input logic [4:0] o, input logic [4:0] r, input logic [31:0] d, input logic w, input logic [31:0] p);
    e_op = o; e_rd = r; e_data = d; e_wen = w; e_pc = p;
  endtask
  task automatic zero_exp();
    set_rec(0, 0, 0, 0, 0);
    e_stall = 0; e_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0; e_err = 0; e_mis = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (chk) begin
      if (o_stall) stall_cnt++;
      if (bus.req) begin
        lb_be = bus.be; lb_wd = bus.wdata; lb_addr = bus.addr;
      end
      check("stall", o_stall, e_stall);
      check("fwd_data", ow_rd_mem, alu);
      check("fwd_addr", ow_rd_addr_mem, rd);
      check("fwd_wen", ow_rd_mem_wr_en, fwd_wen(op, rd));
      check("req", bus.req, e_req);
      if (e_req) begin
        check("we", bus.we, e_we);
        check("addr", bus.addr, e_addr);
        check("be", bus.be, e_be);
        check("wdata", bus.wdata, e_wdata);
      end
      check("opcode", or_opcode, e_op);
      check("rd_addr", or_rd_addr, e_rd);
      check("rd_data", or_rd_data, e_data);
      check("wr_en", or_rd_wr_en, e_wen);
      check("pc", or_pc, e_pc);
      check("bus_err", or_bus_err, e_err);
      check("misaligned", or_misaligned, e_mis);
    end
  // Presents one instruction and plays the memory side; ack_at is the BUSY cycle that acks (-1 = never).
  task automatic issue(input logic [4:0] o, input logic [4:0] r, input logic [31:0] al, input logic [31:0] s2,
                       input logic [2:0] f, input logic [31:0] p, input int ack_at, input logic [31:0] rdat);
    logic mem, mis;
    op = o; rd = r; alu = al; rs2 = s2; f3 = f; pc = p;
    mis = misaligned(o, f, int'(al[1:0]));
    mem = (o == L_OP || o == S_OP) && !mis;
    bus.ack = $urandom_range(0, 3) == 0;
    bus.rdata = $urandom;
    e_stall = mem;
    tick();
    e_err = 0;
    e_mis = mis;
    if (!mem) begin
      e_req = 0;
      set_rec(o, r, (o == JAL_OP || o == JALR_OP) ? p + 4 : al, writes_rd(o) && r != 0 && !mis, p);
      bus.ack = 0;
      return;
    end
    e_req = 1; e_we = o == S_OP; e_addr = al & ~32'h3;
    e_be = ref_be(f, int'(al[1:0])); e_wdata = ref_wd(f, s2);
    set_rec(0, 0, 0, 0, 0);
    for (int j = 0; j < WM; j++) begin
      bus.ack = j == ack_at;
      bus.rdata = j == ack_at ? rdat : $urandom;
      e_stall = j != ack_at && j != WM - 1;
      tick();
      if (j == ack_at) begin
        e_req = 0;
        set_rec(o, r, o == L_OP ? ref_load(f, int'(al[1:0]), rdat) : al, o == L_OP && r != 0, p);
        break;
      end
      if (j == WM - 1) begin
        e_req = 0;
        e_err = 1;
      end
    end
    bus.ack = 0;
  endtask
  logic [4:0] opl [11] = '{5'd0, R_OP, I_OP, L_OP, S_OP, B_OP, JAL_OP, JALR_OP, LUI_OP, AUIPC_OP, SYS_OP};
  logic [2:0] f3l [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
  initial begin
    op = 0; rd = 0; alu = 0; rs2 = 0; f3 = 0; pc = 0; bus.ack = 0; bus.rdata = 0;
    zero_exp();
    repeat (2) tick();
    chk = 1;
    bus.ack = 1;
    tick();
    bus.ack = 0;
    rst_n = 1;
    issue(S_OP, 5'd3, 32'h103, 32'h11223344, 3'b000, 32'h200, 1, 0);
    #1 check("lit_sb_addr", lb_addr, 32'h100);
    check("lit_sb_be", lb_be, 4'b1000);
    check("lit_sb_wdata", lb_wd, 32'h44444444);
    check("lit_sb_wen", or_rd_wr_en, 0);
    issue(L_OP, 5'd4, 32'h101, 0, 3'b000, 32'h204, 0, 32'h000080FF);
    #1 check("lit_lb", or_rd_data, 32'hFFFFFF80);
    issue(L_OP, 5'd4, 32'h101, 0, 3'b100, 32'h208, 2, 32'h000080FF);
    #1 check("lit_lbu", or_rd_data, 32'h00000080);
    stall_cnt = 0;
    issue(L_OP, 5'd5, 32'h102, 0, 3'b001, 32'h20C, 4, 32'h80010000);
    #1 check("lit_lh", or_rd_data, 32'hFFFF8001);
    check("lit_lh_stall", stall_cnt, 5);
    issue(JAL_OP, 5'd1, 32'h1234, 0, 3'b000, 32'h40, -1, 0);
    #1 check("lit_jal_data", or_rd_data, 32'h44);
    check("lit_jal_wen", or_rd_wr_en, 1);
    issue(JAL_OP, 5'd0, 32'h1234, 0, 3'b000, 32'h40, -1, 0);
    #1 check("lit_jal_x0_wen", or_rd_wr_en, 0);
    issue(L_OP, 5'd6, 32'h10, 0, 3'b010, 32'h50, -1, 0);
    #1 check("lit_abort_err", or_bus_err, 1);
    check("lit_abort_req", bus.req, 0);
    check("lit_abort_wen", or_rd_wr_en, 0);
    issue(L_OP, 5'd6, 32'h14, 0, 3'b010, 32'h54, WM - 1, 32'hCAFEF00D);
    #1 check("lit_late_ack", or_rd_data, 32'hCAFEF00D);
    issue(L_OP, 5'd7, 32'h20, 32'h5, 3'b010, 32'h60, -1, 0);
    op = L_OP; rd = 7; alu = 32'h24; rs2 = 32'h5; f3 = 3'b010; pc = 32'h64;
    e_stall = 1;
    tick();
    e_err = 0; e_req = 1; e_we = 0; e_addr = 32'h24; e_be = 4'hF; e_wdata = 32'h5;
    tick();
    rst_n = 0; bus.ack = 1; bus.rdata = 32'hDEADBEEF; e_stall = 0;
    tick();
    zero_exp();
    bus.ack = 0; op = 0; rd = 0; alu = 0; rs2 = 0; f3 = 0; pc = 0;
    tick();
    rst_n = 1;
    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(0, 9);
      issue(opl[$urandom_range(0, 10)], $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom),
            $urandom, $urandom, f3l[$urandom_range(0, 6)], $urandom, k >= WM ? -1 : k, $urandom);
    end
    issue(0, 0, 0, 0, 0, 0, -1, 0);
    tick();
    chk = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
